// File: rtl/branch_unit_pkg.sv
// Shared definitions for the ID-stage branch resolver: instruction constants,
// branch kinds, stall FSM encoding and the branch decoder.
package branch_unit_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } bru_state_e;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ
  } br_kind_e;

  function automatic br_kind_e decode_kind(input logic [5:0] op, input logic [4:0] rt);
    br_kind_e k;
    k = BR_NONE;
    case (op)
      OP_BEQ:  k = BR_BEQ;
      OP_BNE:  k = BR_BNE;
      OP_BLEZ: k = BR_BLEZ;
      OP_BGTZ: k = BR_BGTZ;
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      k = BR_BLTZ;
        else if (rt == RT_BGEZ) k = BR_BGEZ;
      end
      default: k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Bundle of ID-stage, forwarding and result signals around the branch resolver.
// The pipeline side drives through master; branch_unit sits on slave.
interface branch_unit_if
  import branch_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) ();

  logic              id_valid;
  logic [5:0]        id_op;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [15:0]       id_imm;
  logic [PC_W-1:0]   id_pc4;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              ex_regwr;
  logic              ex_memtoreg;
  logic [4:0]        ex_wr_dst;
  logic [DATA_W-1:0] ex_alu_out;
  logic              mem_regwr;
  logic [4:0]        mem_wr_dst;
  logic [DATA_W-1:0] mem_wdata;

  logic              br_is_branch;
  logic              br_stall;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              br_flush;
  logic [CNT_W-1:0]  perf_branches;
  logic [CNT_W-1:0]  perf_taken;
  logic [CNT_W-1:0]  perf_stalls;
  bru_state_e        dbg_state;

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_imm, id_pc4, rd1, rd2,
           ex_regwr, ex_memtoreg, ex_wr_dst, ex_alu_out,
           mem_regwr, mem_wr_dst, mem_wdata,
    input  br_is_branch, br_stall, br_taken, br_target, br_flush,
           perf_branches, perf_taken, perf_stalls, dbg_state
  );

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_imm, id_pc4, rd1, rd2,
           ex_regwr, ex_memtoreg, ex_wr_dst, ex_alu_out,
           mem_regwr, mem_wr_dst, mem_wdata,
    output br_is_branch, br_stall, br_taken, br_target, br_flush,
           perf_branches, perf_taken, perf_stalls, dbg_state
  );

endinterface

// File: rtl/branch_fwd_mux.sv
// Operand select for one branch source: $0, EX ALU result, MEM writeback or
// the register file, with EX taking priority as the youngest producer.
module branch_fwd_mux #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_regwr,
  input  logic              ex_memtoreg,
  input  logic [4:0]        ex_wr_dst,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              mem_regwr,
  input  logic [4:0]        mem_wr_dst,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = rf_data;
    if (src == 5'd0) begin
      data = '0;
    end else if (ex_regwr && !ex_memtoreg && (ex_wr_dst == src)) begin
      data = ex_alu_out;
    end else if (mem_regwr && (mem_wr_dst == src)) begin
      data = mem_wdata;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch resolver: forwarding, condition evaluation, load-use stall FSM,
// target and registered flush. Optional saturating counters via BRU_PERF_CNT_EN.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int PC_W           = 32,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 16
) (
  input logic         clk,
  input logic         rst,
  branch_unit_if.slave bus
);

  localparam int CW = $clog2(LOAD_STALL_CYC + 1);

  br_kind_e          kind;
  logic              is_branch;
  logic              uses_rt;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic              r1_neg;
  logic              r1_zero;
  logic              cond;
  logic              hazard;
  logic              stall;
  logic              taken;
  logic              flush_q;
  bru_state_e        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;

  assign kind      = decode_kind(bus.id_op, bus.id_rt);
  assign is_branch = (kind != BR_NONE);
  assign uses_rt   = (kind == BR_BEQ) || (kind == BR_BNE);

  branch_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .src         (bus.id_rs),
    .rf_data     (bus.rd1),
    .ex_regwr    (bus.ex_regwr),
    .ex_memtoreg (bus.ex_memtoreg),
    .ex_wr_dst   (bus.ex_wr_dst),
    .ex_alu_out  (bus.ex_alu_out),
    .mem_regwr   (bus.mem_regwr),
    .mem_wr_dst  (bus.mem_wr_dst),
    .mem_wdata   (bus.mem_wdata),
    .data        (r1)
  );

  branch_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .src         (bus.id_rt),
    .rf_data     (bus.rd2),
    .ex_regwr    (bus.ex_regwr),
    .ex_memtoreg (bus.ex_memtoreg),
    .ex_wr_dst   (bus.ex_wr_dst),
    .ex_alu_out  (bus.ex_alu_out),
    .mem_regwr   (bus.mem_regwr),
    .mem_wr_dst  (bus.mem_wr_dst),
    .mem_wdata   (bus.mem_wdata),
    .data        (r2)
  );

  // Signed compares against zero reduce to the sign bit and a zero test.
  assign r1_neg  = r1[DATA_W-1];
  assign r1_zero = (r1 == '0);

  always_comb begin
    cond = 1'b0;
    case (kind)
      BR_BEQ:  cond = (r1 == r2);
      BR_BNE:  cond = (r1 != r2);
      BR_BLEZ: cond = r1_neg | r1_zero;
      BR_BGTZ: cond = ~r1_neg & ~r1_zero;
      BR_BLTZ: cond = r1_neg;
      BR_BGEZ: cond = ~r1_neg;
      default: cond = 1'b0;
    endcase
  end

  assign hazard = bus.id_valid && is_branch && bus.ex_regwr && bus.ex_memtoreg &&
                  (bus.ex_wr_dst != 5'd0) &&
                  ((bus.ex_wr_dst == bus.id_rs) || (uses_rt && (bus.ex_wr_dst == bus.id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The first stall cycle is spent in IDLE, so WAIT only covers the remainder.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = hazard;
        if (hazard && (LOAD_STALL_CYC > 1)) begin
          state_n = ST_WAIT;
          cnt_n   = CW'(LOAD_STALL_CYC - 1);
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt == CW'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign taken = bus.id_valid && is_branch && !stall && cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= taken;
  end

  assign bus.br_is_branch = is_branch;
  assign bus.br_stall     = stall;
  assign bus.br_taken     = taken;
  assign bus.br_target    = bus.id_pc4 + PC_W'({{14{bus.id_imm[15]}}, bus.id_imm, 2'b00});
  assign bus.br_flush     = flush_q;
  assign bus.dbg_state    = state;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] n_branches, n_taken, n_stalls;
  logic             resolved;

  assign resolved = bus.id_valid && is_branch && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_branches <= '0;
      n_taken    <= '0;
      n_stalls   <= '0;
    end else begin
      if (resolved && (n_branches != '1)) n_branches <= n_branches + CNT_W'(1);
      if (taken && (n_taken != '1))       n_taken    <= n_taken + CNT_W'(1);
      if (stall && (n_stalls != '1))      n_stalls   <= n_stalls + CNT_W'(1);
    end
  end

  assign bus.perf_branches = n_branches;
  assign bus.perf_taken    = n_taken;
  assign bus.perf_stalls   = n_stalls;
`else
  assign bus.perf_branches = {CNT_W{1'b0}};
  assign bus.perf_taken    = {CNT_W{1'b0}};
  assign bus.perf_stalls   = {CNT_W{1'b0}};
`endif

endmodule
